// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among N byte producers. Each producer offers a
// byte with a valid/ready handshake; a round-robin pick (starting one past the
// last granted index) decides who is accepted. The accepted byte is launched
// with a one-cycle tx_start pulse, after which the arbiter waits for the
// transmitter's busy flag to rise and then fall before accepting again. If
// busy never rises within BUSY_TIMEOUT clocks the byte is dropped and
// err_timeout pulses.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   req_valid    [N]     producer i offers a byte
//   req_data     [N*8]   byte of producer i in bits [8i+7:8i]
//   req_ready    [N]     one-hot accept (combinational, IDLE only)
//   tx_start             one-cycle start pulse to the transmitter
//   tx_data      [8]     byte to the transmitter, held for the whole grant
//   tx_busy              transmitter busy flag
//   grant_id     [clog2(N)] index being served; holds last value when idle
//   active               high while a grant is in progress
//   err_timeout          one-cycle pulse when busy never rose
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N*8-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    localparam int IDW = $clog2(N);

    // Width-matched constants for the modulo-N wrap and the timeout counter.
    localparam logic [IDW:0]   N_W       = (IDW+1)'(N);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);
    localparam logic [7:0]     TO_LAST   = 8'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]     TO_ARM    = 8'(BUSY_TIMEOUT - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_start_q, tx_start_d;
    logic           active_q, active_d;
    logic           err_timeout_q, err_timeout_d;
    logic [7:0]     busy_cnt_q, busy_cnt_d;

    // -----------------------------------------------------------------------
    // Per-requester byte slices.
    // -----------------------------------------------------------------------
    logic [7:0] req_byte [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_byte
            assign req_byte[gi] = req_data[gi*8 +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Candidate k is the index at offset k+1 from the last grant, wrapped
    // modulo N. Candidate 0 therefore has the highest priority, and the last
    // granted index (offset N) the lowest.
    // -----------------------------------------------------------------------
    logic [IDW:0]   cand_sum   [N];
    logic [IDW-1:0] cand_idx   [N];
    logic [N-1:0]   cand_valid;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand_sum[gi]   = {1'b0, last_grant_q} + (IDW+1)'(gi + 1);
            assign cand_idx[gi]   = (cand_sum[gi] >= N_W) ? IDW'(cand_sum[gi] - N_W)
                                                          : IDW'(cand_sum[gi]);
            assign cand_valid[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    logic           pick_found;
    logic [IDW-1:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!pick_found && cand_valid[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    // Accept happens only in IDLE; reset masks ready so nothing is handshaken
    // while the registers are being held in their reset values.
    logic accept;
    assign accept = (state_q == ST_IDLE) && pick_found && !reset;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        active_d      = active_q;
        err_timeout_d = 1'b0;
        busy_cnt_d    = busy_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_data_d    = req_byte[pick_idx];
                    grant_id_d   = pick_idx;
                    last_grant_d = pick_idx;
                    active_d     = 1'b1;
                    // Registered, so the pulse is visible during LAUNCH.
                    tx_start_d   = 1'b1;
                    state_d      = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                busy_cnt_d = '0;
                state_d    = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                // The error pulse is raised one cycle ahead so it lands in the
                // last WAIT_BUSY cycle; the exit to IDLE follows it.
                if (busy_cnt_q == TO_LAST) begin
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    busy_cnt_d = busy_cnt_q + 8'd1;
                    if (busy_cnt_q == TO_ARM) begin
                        err_timeout_d = 1'b1;
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= LAST_IDX;
            grant_id_q    <= '0;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            active_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            busy_cnt_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            active_q      <= active_d;
            err_timeout_q <= err_timeout_d;
            busy_cnt_q    <= busy_cnt_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (N=4, BUSY_TIMEOUT=8). A small UART
// transmitter model (16 clocks per bit) drives tx_busy and a serial line; a
// matching receiver captures frames. Monitors log grants, tx_start cycles and
// tx_busy falling cycles. Each test task drives stimulus and checks inline.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int BT  = 8;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_timeout;

    logic        uart_en = 1'b1;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    uart_tx_arbiter #(
        .N            (N),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    // ---------------- UART transmitter model ----------------
    logic       m_busy  = 1'b0;
    logic       serial  = 1'b1;
    logic [9:0] m_shift = 10'h3FF;
    int         m_bit   = 0;
    int         m_clk   = 0;

    always @(posedge clk) begin
        if (reset || !uart_en) begin
            m_busy <= 1'b0;
            serial <= 1'b1;
        end else if (!m_busy) begin
            if (tx_start) begin
                m_busy  <= 1'b1;
                m_shift <= {1'b1, tx_data, 1'b0};
                m_bit   <= 0;
                m_clk   <= 0;
                serial  <= 1'b0;
            end
        end else begin
            if (m_clk == CPB - 1) begin
                m_clk <= 0;
                if (m_bit == 9) begin
                    m_busy <= 1'b0;
                    serial <= 1'b1;
                end else begin
                    m_bit  <= m_bit + 1;
                    serial <= m_shift[m_bit + 1];
                end
            end else begin
                m_clk <= m_clk + 1;
            end
        end
    end

    assign tx_busy = uart_en & m_busy;

    // ---------------- UART receiver (mid-bit sampling) ----------------
    logic       r_act  = 1'b0;
    int         r_cnt  = 0;
    logic [7:0] r_byte = 8'h00;
    logic [7:0] rx_log[$];

    always @(posedge clk) begin
        if (reset || !uart_en) begin
            r_act <= 1'b0;
        end else if (!r_act) begin
            if (!serial) begin
                r_act <= 1'b1;
                r_cnt <= 1;
            end
        end else begin
            r_cnt <= r_cnt + 1;
            if (r_cnt >= 24 && r_cnt <= 136 && (r_cnt % 16) == 8)
                r_byte[(r_cnt - 24) / 16] <= serial;
            if (r_cnt == 152) begin
                rx_log.push_back(r_byte);
                $display("rx frame %02h", r_byte);
                r_act <= 1'b0;
            end
        end
    end

    // ---------------- Monitors ----------------
    int grant_log[$];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                grant_log.push_back(i);
                $display("accept req=%0d data=%02h", i, req_data[i*8 +: 8]);
            end
        end
    end

    int   cyc = 0;
    logic prev_busy = 1'b0;
    logic overlap = 1'b0;
    int   start_log[$];
    int   fall_log[$];

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_busy <= tx_busy;
        if (prev_busy && !tx_busy) fall_log.push_back(cyc);
        if (tx_start) start_log.push_back(cyc);
        if (tx_start && tx_busy) overlap <= 1'b1;
    end

    // ---------------- Helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!active && !tx_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            $display("FAIL %s_idle_wait: active=%0b busy=%0b, required idle within 600 cycles",
                     name, active, tx_busy);
            failures++;
        end
    endtask

    task automatic wait_grants(input string name, input int base, input int count, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (grant_log.size() - base >= count) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            $display("FAIL %s_grant_wait: got %0d grants, required %0d",
                     name, grant_log.size() - base, count);
            failures++;
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL reset_ready: got %b, required 0000", req_ready);
            failures++;
        end
        checks++;
        if (tx_start !== 1'b0 || active !== 1'b0 || err_timeout !== 1'b0) begin
            $display("FAIL reset_ctrl: start=%b active=%b err=%b, required 0 0 0",
                     tx_start, active, err_timeout);
            failures++;
        end
        checks++;
        if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
            $display("FAIL reset_data: tx_data=%02h grant_id=%0d, required 00 0", tx_data, grant_id);
            failures++;
        end
        req_valid = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL reset_idle_ready: got %b, required 0000", req_ready);
            failures++;
        end
    endtask

    task automatic test_single();
        int  gbase, rbase;
        bit  ok;
        gbase = grant_log.size();
        rbase = rx_log.size();
        req_data[7:0] = 8'h55;
        req_valid     = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL single_ready: got %b, required 0001", req_ready);
            failures++;
        end
        tick();  // T+1
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55 || grant_id !== 2'd0 || active !== 1'b1) begin
            $display("FAIL single_launch: start=%b data=%02h id=%0d active=%b, required 1 55 0 1",
                     tx_start, tx_data, grant_id, active);
            failures++;
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL single_ready_busy: got %b, required 0000", req_ready);
            failures++;
        end
        tick();  // T+2
        checks++;
        if (tx_start !== 1'b0 || active !== 1'b1) begin
            $display("FAIL single_pulse_width: start=%b active=%b, required 0 1", tx_start, active);
            failures++;
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            $display("FAIL single_busy_fall: busy still %b after 300 cycles, required 0", tx_busy);
            failures++;
        end
        checks++;
        if (grant_log.size() - gbase != 1) begin
            $display("FAIL single_one_accept: got %0d accepts, required 1", grant_log.size() - gbase);
            failures++;
        end
        req_valid = 4'b0000;
        tick();
        tick();
        checks++;
        if (active !== 1'b0) begin
            $display("FAIL single_active_drop: got %b, required 0", active);
            failures++;
        end
        checks++;
        if (rx_log.size() - rbase != 1 || rx_log[rbase] !== 8'h55) begin
            $display("FAIL single_frame: got %0d frames first=%02h, required 1 frame 55",
                     rx_log.size() - rbase, (rx_log.size() > rbase) ? rx_log[rbase] : 8'hxx);
            failures++;
        end
    endtask

    task automatic test_round_robin();
        int gbase, rbase;
        int exp_id [5];
        logic [7:0] exp_byte [4];
        exp_id   = '{0, 1, 2, 3, 0};
        exp_byte = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        do_reset();
        gbase = grant_log.size();
        rbase = rx_log.size();
        req_data  = 32'hA3A2A1A0;
        req_valid = 4'b1111;
        wait_grants("rr", gbase, 5, 1500);
        req_valid = 4'b0000;
        wait_idle("rr");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (grant_log.size() <= gbase + k || grant_log[gbase + k] != exp_id[k]) begin
                $display("FAIL rr_order[%0d]: got %0d, required %0d", k,
                         (grant_log.size() > gbase + k) ? grant_log[gbase + k] : -1, exp_id[k]);
                failures++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_log.size() <= rbase + k || rx_log[rbase + k] !== exp_byte[k]) begin
                $display("FAIL rr_frame[%0d]: got %02h, required %02h", k,
                         (rx_log.size() > rbase + k) ? rx_log[rbase + k] : 8'hxx, exp_byte[k]);
                failures++;
            end
        end
    endtask

    task automatic test_wrap();
        int gbase;
        do_reset();
        gbase     = grant_log.size();
        req_valid = 4'b0100;
        wait_grants("wrap_first", gbase, 1, 50);
        req_valid = 4'b0000;
        wait_idle("wrap_first");
        gbase     = grant_log.size();
        req_valid = 4'b1001;
        wait_grants("wrap", gbase, 2, 600);
        req_valid = 4'b0000;
        wait_idle("wrap");
        checks++;
        if (grant_log.size() < gbase + 2 || grant_log[gbase] != 3) begin
            $display("FAIL wrap_first_pick: got %0d, required 3",
                     (grant_log.size() > gbase) ? grant_log[gbase] : -1);
            failures++;
        end
        checks++;
        if (grant_log.size() < gbase + 2 || grant_log[gbase + 1] != 0) begin
            $display("FAIL wrap_second_pick: got %0d, required 0",
                     (grant_log.size() > gbase + 1) ? grant_log[gbase + 1] : -1);
            failures++;
        end
    endtask

    task automatic test_timeout();
        bit early;
        uart_en = 1'b0;
        tick();
        req_data[15:8] = 8'h5A;
        req_valid      = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            $display("FAIL to_ready: got %b, required 0010", req_ready);
            failures++;
        end
        tick();  // T+1
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd1 || tx_data !== 8'h5A) begin
            $display("FAIL to_launch: start=%b id=%0d data=%02h, required 1 1 5a",
                     tx_start, grant_id, tx_data);
            failures++;
        end
        req_valid = 4'b0000;
        early = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();  // T+2 .. T+8
            if (err_timeout !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            $display("FAIL to_early: err_timeout seen before start+8, required 0");
            failures++;
        end
        tick();  // T+9
        checks++;
        if (err_timeout !== 1'b1 || active !== 1'b1) begin
            $display("FAIL to_pulse: err=%b active=%b, required 1 1", err_timeout, active);
            failures++;
        end
        req_valid = 4'b0110;
        tick();  // T+10
        checks++;
        if (err_timeout !== 1'b0 || active !== 1'b0) begin
            $display("FAIL to_after: err=%b active=%b, required 0 0", err_timeout, active);
            failures++;
        end
        checks++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL to_next_pick: got %b, required 0100", req_ready);
            failures++;
        end
        req_valid = 4'b0000;
        tick();
        uart_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        int  gbase;
        bit  ok;
        gbase          = grant_log.size();
        req_data[7:0]  = 8'h33;
        req_valid      = 4'b0001;
        wait_grants("rst_mid", gbase, 1, 20);
        req_valid = 4'b0000;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            $display("FAIL rst_mid_busy_rise: busy=%b, required 1", tx_busy);
            failures++;
        end
        repeat (10) tick();
        req_valid = 4'b1111;
        reset     = 1'b1;
        #1;
        checks++;
        if (tx_start !== 1'b0 || active !== 1'b0 || req_ready !== 4'b0000) begin
            $display("FAIL rst_mid_clear: start=%b active=%b ready=%b, required 0 0 0000",
                     tx_start, active, req_ready);
            failures++;
        end
        checks++;
        if (grant_id !== 2'd0 || tx_data !== 8'h00) begin
            $display("FAIL rst_mid_regs: id=%0d data=%02h, required 0 00", grant_id, tx_data);
            failures++;
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL rst_mid_first: got %b, required 0001", req_ready);
            failures++;
        end
        tick();
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h33) begin
            $display("FAIL rst_mid_regrant: start=%b id=%0d data=%02h, required 1 0 33",
                     tx_start, grant_id, tx_data);
            failures++;
        end
        req_valid = 4'b0000;
        wait_idle("rst_mid");
    endtask

    task automatic test_back_to_back();
        int  sbase, fbase;
        bit  ok;
        sbase          = start_log.size();
        fbase          = fall_log.size();
        req_data[15:8] = 8'h77;
        req_valid      = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (start_log.size() - sbase >= 2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        req_valid = 4'b0000;
        checks++;
        if (!ok) begin
            $display("FAIL b2b_starts: got %0d starts, required 2", start_log.size() - sbase);
            failures++;
        end
        wait_idle("b2b");
        if (ok) begin
            checks++;
            if (fall_log.size() <= fbase || start_log[sbase + 1] - fall_log[fbase] != 2) begin
                $display("FAIL b2b_gap: got %0d clocks from busy fall to start, required 2",
                         (fall_log.size() > fbase) ? start_log[sbase + 1] - fall_log[fbase] : -1);
                failures++;
            end
            checks++;
            if (start_log[sbase + 1] - start_log[sbase] != 163) begin
                $display("FAIL b2b_period: got %0d clocks between starts, required 163",
                         start_log[sbase + 1] - start_log[sbase]);
                failures++;
            end
        end
        checks++;
        if (overlap !== 1'b0) begin
            $display("FAIL b2b_overlap: tx_start seen with tx_busy high (%b), required 0", overlap);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded 2 ms, required completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among N byte-producing requesters. Each requester offers a byte with a valid/ready handshake. The arbiter selects one, launches it into the UART transmitter with a one-cycle start pulse, and waits for the transmitter's busy flag to rise and fall before granting again. It sits between the design's message sources (status reporters, debug dumpers) and the single 9600-baud TX line.

## Interface
- `N`, 4: number of requesters, legal range 2..8.
- `BUSY_TIMEOUT`, 8: clocks to wait for `tx_busy` to rise after a start pulse before aborting; legal range 2..255.
- `clk` input 1: system clock, 50 MHz.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input N: requester i offers a byte.
- `req_data` input N*8: byte of requester i in bits [8i+7:8i].
- `req_ready` output N: one-hot; a transfer occurs on a cycle where `req_valid[i] & req_ready[i]`.
- `tx_start` output 1: one-cycle start pulse to the UART transmitter.
- `tx_data` output 8: byte to the UART transmitter; held stable from the start pulse until the grant completes.
- `tx_busy` input 1: transmitter busy flag; rises one clock after the start pulse is sampled.
- `grant_id` output clog2(N): index of the requester currently being served; holds the last value when idle.
- `active` output 1: high from the accept cycle + 1 until the return to IDLE.
- `err_timeout` output 1: one-cycle pulse when `tx_busy` never rose.

## Operation
- **Reset values:** state IDLE, `tx_start` 0, `tx_data` 0x00, `grant_id` 0, `active` 0, `err_timeout` 0, `last_grant` N-1, so requester 0 has first priority. `req_ready` is forced to 0 while `reset` is high.
- **FSM states:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - Pick the first i with `req_valid[i]=1`, scanning `last_grant+1`, `+2`, … modulo N.
  - `req_ready[pick]=1` combinationally, all others 0. If no valid request, `req_ready=0`.
  - On accept: latch `tx_data <= req_data[pick]`, `grant_id <= pick`, `last_grant <= pick`, `active <= 1`, go to LAUNCH.
- **LAUNCH:** `tx_start=1` for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `tx_busy=1`, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT-1` without busy, pulse `err_timeout`, drop `active`, and go to IDLE. The byte is dropped, not retried, and `last_grant` keeps the aborted index.
- **WAIT_DONE:** when `tx_busy=0`, drop `active` and go to IDLE.
- **No deadlock on busy already high:** if `tx_busy` is already 1 in IDLE (transmitter owned elsewhere), still accept, because WAIT_BUSY exits immediately on busy=1.
- **Fairness:** a requester that holds `req_valid` high continuously is served at most once per N grants while others are requesting.
- **Changing requests:** `req_valid` deasserted in IDLE before the accept cycle simply changes the pick. No request is lost because no ready was given.
- **`req_data` stability:** `req_data` is only sampled in the accept cycle; later changes are ignored.
- **Reset mid-grant:** return to the reset values immediately. The in-flight UART frame is not the arbiter's concern.

## Timing
- Accept at cycle T (IDLE, `req_valid & req_ready`):
  - T+1: `tx_start=1`, `tx_data` valid, `active=1`.
  - T+2: `tx_busy=1` is expected.
- Grant ends one cycle after `tx_busy` is sampled low in WAIT_DONE. The next accept can happen in that same IDLE cycle.
- Minimum gap between the `tx_busy` falling edge and the next `tx_start` is 2 clocks.
- Timeout abort: `err_timeout` pulses in cycle T+1+`BUSY_TIMEOUT`, and IDLE is entered on the following cycle.
- All outputs except `req_ready` are registered. `req_ready` is a combinational function of state, `last_grant` and `req_valid`.

## Test plan
1. **Single request:** after reset, `req_valid=4'b0001` with byte 0x55, UART model with CLKS_PER_BIT=16.
   - `req_ready[0]` goes high at T; `tx_start` pulses at T+1 with `tx_data=0x55`; `grant_id=0`.
   - No second accept until `tx_busy` falls; the captured serial frame is 0x55.
2. **Round-robin:** all four requesters valid continuously with data 0xA0..0xA3.
   - Grant order is 0,1,2,3,0.
   - Frames arrive in order 0xA0, 0xA1, 0xA2, 0xA3.
3. **Wrap after a late requester:** last grant 2, then only requesters 0 and 3 valid.
   - Next grant is 3, then 0.
4. **Timeout:** `tx_busy` tied to 0, `BUSY_TIMEOUT=8`.
   - `err_timeout` pulses exactly 8 cycles after `tx_start`.
   - The FSM is in IDLE the next cycle and grants the next requester.
5. **Reset mid-grant:** assert `reset` during WAIT_DONE.
   - `tx_start`, `active` and `req_ready` go to 0 immediately.
   - After release, requester 0 is granted first.
6. **Back-to-back:** requester 1 is valid continuously.
   - Its second `tx_start` occurs 2 clocks after `tx_busy` falls, and is never asserted while `tx_busy=1`.
